// File: rtl/zuart_param_controller.sv
// Parameterised UART transmitter/receiver pair sharing one clock and enable.
// Ports:
//   clk_i, rst_n_i            : clock, asynchronous active-low reset
//   en_i                      : block enable; low parks both FSMs in IDLE
//   tx_valid_i/tx_data_i      : transmit request and payload
//   tx_ready_o/tx_done_o      : accept-ready, end-of-frame pulse
//   tx_pin_o                  : serial line out (idle high)
//   rx_pin_i                  : asynchronous serial line in
//   rx_data_o/rx_valid_o      : last received payload, update pulse
//   rx_parity_err_o/rx_frame_err_o : status, qualified by rx_valid_o
module zuart_param_controller #(
  parameter int unsigned BAUD_DIV  = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 tx_valid_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  output logic                 tx_ready_o,
  output logic                 tx_done_o,
  output logic                 tx_pin_o,
  input  logic                 rx_pin_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_frame_err_o
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(BAUD_DIV - 2);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD_PAR = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               tx_state_q, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_pin_q, tx_pin_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_done_q, tx_done_d;
  logic                 tx_bit_end;

  state_e               rx_state_q, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
  logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 rx_bit_end;
  logic                 rx_fall;

  assign tx_bit_end = (tx_cnt_q == CNT_LAST);
  assign rx_bit_end = (rx_cnt_q == CNT_LAST);
  // Falling edge on the synchronised line; needs a high sample first, so a
  // line stuck low after a frame error cannot start a new frame.
  assign rx_fall    = rx_prev_q & ~rx_sync_q;

  // TX next-state: pin value for the next bit is loaded on the last cycle of the current bit.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = '0;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pin_d   = tx_pin_q;
    tx_ready_d = 1'b0;
    tx_done_d  = 1'b0;
    if (tx_state_q != S_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + CNT_W'(1);
    unique case (tx_state_q)
      S_IDLE: begin
        tx_pin_d   = 1'b1;
        tx_ready_d = 1'b1;
        if (tx_valid_i && tx_ready_q) begin
          tx_state_d = S_START;
          tx_pin_d   = 1'b0;
          tx_ready_d = 1'b0;
          tx_shift_d = tx_data_i;
          tx_par_d   = ODD_PAR ? ~^tx_data_i : ^tx_data_i;
        end
      end
      S_START: begin
        if (tx_bit_end) begin
          tx_state_d = S_DATA;
          tx_pin_d   = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          tx_bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == DATA_LAST) begin
            tx_bit_d = '0;
            if (HAS_PAR) begin
              tx_state_d = S_PARITY;
              tx_pin_d   = tx_par_q;
            end else begin
              tx_state_d = S_STOP;
              tx_pin_d   = 1'b1;
            end
          end else begin
            tx_pin_d   = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
            tx_bit_d   = tx_bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (tx_bit_end) begin
          tx_state_d = S_STOP;
          tx_pin_d   = 1'b1;
          tx_bit_d   = '0;
        end
      end
      S_STOP: begin
        // Registered pulse must be set one cycle early to land on the last cycle.
        if (tx_cnt_q == CNT_PRE && tx_bit_q == STOP_LAST) tx_done_d = 1'b1;
        if (tx_bit_end) begin
          if (tx_bit_q == STOP_LAST) begin
            tx_state_d = S_IDLE;
            tx_ready_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + BIT_W'(1);
          end
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (!en_i) begin
      tx_state_d = S_IDLE;
      tx_cnt_d   = '0;
      tx_pin_d   = 1'b1;
      tx_ready_d = 1'b0;
      tx_done_d  = 1'b0;
    end
  end

  // RX next-state: one sample per bit, at mid-bit after the start-bit recheck.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = '0;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    if (rx_state_q != S_IDLE) rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + CNT_W'(1);
    unique case (rx_state_q)
      S_IDLE: begin
        if (rx_fall) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_state_d = S_DATA;
            rx_bit_d   = '0;
            rx_par_d   = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (rx_bit_end) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_par_d   = rx_par_q ^ rx_sync_q;
          if (rx_bit_q == DATA_LAST) rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
          else                       rx_bit_d   = rx_bit_q + BIT_W'(1);
        end
      end
      S_PARITY: begin
        if (rx_bit_end) begin
          rx_par_d   = rx_par_q ^ rx_sync_q;
          rx_state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Only the first stop bit is checked; a second one just looks like idle.
        if (rx_bit_end) begin
          rx_state_d = S_IDLE;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          rx_perr_d  = HAS_PAR && (rx_par_q != ODD_PAR);
          rx_ferr_d  = ~rx_sync_q;
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
    if (!en_i) begin
      rx_state_d = S_IDLE;
      rx_cnt_d   = '0;
      rx_valid_d = 1'b0;
    end
  end

  // State registers for both FSMs and the rx_pin_i synchroniser.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_pin_q   <= 1'b1;
      tx_ready_q <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_pin_q   <= tx_pin_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_meta_q  <= rx_pin_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
    end
  end

  assign tx_ready_o      = tx_ready_q;
  assign tx_done_o       = tx_done_q;
  assign tx_pin_o        = tx_pin_q;
  assign rx_data_o       = rx_data_q;
  assign rx_valid_o      = rx_valid_q;
  assign rx_parity_err_o = rx_perr_q;
  assign rx_frame_err_o  = rx_ferr_q;

endmodule

// File: tb/tb_zuart_param_controller.sv
// Bench for zuart_param_controller: an 8N1 instance for transmit timing and
// an 8E2 instance for receive checks and tx->rx loopback, both at BAUD_DIV=4.
`timescale 1ns/1ps
module tb_zuart_param_controller;

  localparam int unsigned BD = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  always #5 clk = ~clk;

  logic       n1_tx_valid, n1_tx_ready, n1_tx_done, n1_tx_pin;
  logic [7:0] n1_tx_data, n1_rx_data;
  logic       n1_rx_valid, n1_perr, n1_ferr;

  logic       e2_tx_valid, e2_tx_ready, e2_tx_done, e2_tx_pin;
  logic [7:0] e2_tx_data, e2_rx_data;
  logic       e2_rx_valid, e2_perr, e2_ferr;
  logic       e2_rx_pin, loop_sel, drv_pin;

  assign e2_rx_pin = loop_sel ? e2_tx_pin : drv_pin;

  zuart_param_controller #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_n1 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .tx_valid_i(n1_tx_valid), .tx_data_i(n1_tx_data), .tx_ready_o(n1_tx_ready),
    .tx_done_o(n1_tx_done), .tx_pin_o(n1_tx_pin), .rx_pin_i(1'b1),
    .rx_data_o(n1_rx_data), .rx_valid_o(n1_rx_valid),
    .rx_parity_err_o(n1_perr), .rx_frame_err_o(n1_ferr)
  );

  zuart_param_controller #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut_e2 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .tx_valid_i(e2_tx_valid), .tx_data_i(e2_tx_data), .tx_ready_o(e2_tx_ready),
    .tx_done_o(e2_tx_done), .tx_pin_o(e2_tx_pin), .rx_pin_i(e2_rx_pin),
    .rx_data_o(e2_rx_data), .rx_valid_o(e2_rx_valid),
    .rx_parity_err_o(e2_perr), .rx_frame_err_o(e2_ferr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Received words on the 8E2 instance as {data, parity_err, frame_err}.
  logic [9:0] rxq[$];
  int         e2_done_cnt = 0;
  always @(negedge clk) begin
    if (e2_rx_valid) rxq.push_back({e2_rx_data, e2_perr, e2_ferr});
    if (e2_tx_done) e2_done_cnt++;
  end

  typedef struct packed {
    logic [7:0] data;
    logic [9:0] line;   // transmitted bits, index 0 = start bit
  } tx_vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [9:0] exp;    // {data, parity_err, frame_err}
  } rx_vec_t;

  tx_vec_t tx_tab[6];
  rx_vec_t rx_tab[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [26:0] rst_view();
    return {n1_tx_pin, n1_tx_ready, n1_tx_done,
            e2_tx_pin, e2_tx_ready, e2_rx_valid, e2_perr, e2_ferr, e2_rx_data,
            n1_rx_valid, n1_perr, n1_ferr, n1_rx_data};
  endfunction

  // Called at a negedge with n1 ready; checks the whole 40-cycle line trace.
  task automatic send_n1(input logic [7:0] d, input logic [9:0] line, input string tag);
    logic [39:0] pin_tr, done_tr, exp_tr;
    n1_tx_valid = 1'b1;
    n1_tx_data  = d;
    check({tag, " ready"}, 64'(n1_tx_ready), 64'(1));
    @(negedge clk);
    n1_tx_valid = 1'b0;
    n1_tx_data  = '0;
    for (int k = 0; k < 40; k++) begin
      pin_tr[k]  = n1_tx_pin;
      done_tr[k] = n1_tx_done;
      exp_tr[k]  = line[k/4];
      @(negedge clk);
    end
    check({tag, " line"}, 64'(pin_tr), 64'(exp_tr));
    check({tag, " done"}, 64'(done_tr), 64'h80_0000_0000);
    check({tag, " after"}, 64'({n1_tx_ready, n1_tx_done, n1_tx_pin}), 64'(3'b101));
  endtask

  // Called at a negedge; drives one 8E frame then optionally holds the line low.
  task automatic drive_rx(input logic [7:0] d, input logic par, input logic stop, input int low_tail);
    logic [10:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int b = 0; b < 11; b++) begin
      drv_pin = bits[b];
      repeat (BD) @(negedge clk);
    end
    if (low_tail > 0) begin
      drv_pin = 1'b0;
      repeat (low_tail) @(negedge clk);
    end
    drv_pin = 1'b1;
  endtask

  task automatic check_rx(input int base, input logic [9:0] exp, input string tag);
    logic [9:0] got;
    got = 'x;
    check({tag, " count"}, 64'(rxq.size() - base), 64'(1));
    if (rxq.size() > base) got = rxq[base];
    check({tag, " word"}, 64'(got), 64'(exp));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int         base, dbase, t, dones;
    logic [7:0] lb_words[3];
    logic [9:0] pin_hist;

    tx_tab[0] = '{data: 8'h55, line: 10'h2AA};
    tx_tab[1] = '{data: 8'h00, line: 10'h200};
    tx_tab[2] = '{data: 8'hFF, line: 10'h3FE};
    tx_tab[3] = '{data: 8'hA5, line: 10'h34A};
    tx_tab[4] = '{data: 8'h01, line: 10'h202};
    tx_tab[5] = '{data: 8'h80, line: 10'h300};

    rx_tab[0] = '{data: 8'h07, par: 1'b1, stop: 1'b1, exp: {8'h07, 2'b00}};
    rx_tab[1] = '{data: 8'h07, par: 1'b0, stop: 1'b1, exp: {8'h07, 2'b10}};
    rx_tab[2] = '{data: 8'h3C, par: 1'b0, stop: 1'b1, exp: {8'h3C, 2'b00}};
    rx_tab[3] = '{data: 8'h3C, par: 1'b1, stop: 1'b1, exp: {8'h3C, 2'b10}};
    rx_tab[4] = '{data: 8'h81, par: 1'b0, stop: 1'b0, exp: {8'h81, 2'b01}};
    rx_tab[5] = '{data: 8'hFE, par: 1'b1, stop: 1'b1, exp: {8'hFE, 2'b00}};
    rx_tab[6] = '{data: 8'h00, par: 1'b1, stop: 1'b1, exp: {8'h00, 2'b10}};

    lb_words[0] = 8'h00;
    lb_words[1] = 8'hFF;
    lb_words[2] = 8'hA5;

    rst_n = 1'b0; en = 1'b0;
    n1_tx_valid = 1'b0; n1_tx_data = '0;
    e2_tx_valid = 1'b0; e2_tx_data = '0;
    drv_pin = 1'b1; loop_sel = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset state", 64'(rst_view()), 64'({3'b100, 5'b10000, 8'h00, 3'b000, 8'h00}));
    rst_n = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 transmit frames, back to back
    for (int i = 0; i < 6; i++) send_n1(tx_tab[i].data, tx_tab[i].line, $sformatf("tx%0d", i));

    // Enable dropped during data bit 3
    n1_tx_valid = 1'b1; n1_tx_data = 8'h55;
    @(negedge clk);
    n1_tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("en drop bit3 pin", 64'(n1_tx_pin), 64'(0));
    en = 1'b0;
    @(negedge clk);
    check("en drop pin/ready", 64'({n1_tx_pin, n1_tx_ready}), 64'(2'b10));
    dones = 0;
    pin_hist = '1;
    for (int k = 0; k < 50; k++) begin
      if (n1_tx_done) dones++;
      if (!n1_tx_pin) pin_hist = '0;
      @(negedge clk);
    end
    check("en drop no done", 64'(dones), 64'(0));
    check("en drop line idle", 64'(pin_hist), 64'(10'h3FF));
    en = 1'b1;
    @(negedge clk);
    check("re-enable ready", 64'(n1_tx_ready), 64'(1));
    send_n1(tx_tab[0].data, tx_tab[0].line, "tx after en");

    // 8E2 receive vectors
    for (int i = 0; i < 7; i++) begin
      base = rxq.size();
      drive_rx(rx_tab[i].data, rx_tab[i].par, rx_tab[i].stop, 0);
      repeat (10) @(negedge clk);
      check_rx(base, rx_tab[i].exp, $sformatf("rx%0d", i));
    end

    // Stop bit low and line held low: one frame-error word, no restart
    base = rxq.size();
    drive_rx(8'h81, 1'b0, 1'b0, 60);
    check_rx(base, {8'h81, 2'b01}, "ferr hold");
    repeat (10) @(negedge clk);
    base = rxq.size();
    drive_rx(8'h5A, 1'b0, 1'b1, 0);
    repeat (10) @(negedge clk);
    check_rx(base, {8'h5A, 2'b00}, "after ferr");

    // One-cycle glitch, then a real frame right at the recovery bound
    base = rxq.size();
    drv_pin = 1'b0;
    @(negedge clk);
    drv_pin = 1'b1;
    repeat (4) @(negedge clk);
    drive_rx(8'hC3, 1'b0, 1'b1, 0);
    repeat (10) @(negedge clk);
    check_rx(base, {8'hC3, 2'b00}, "glitch");

    // Loopback on the 8E2 instance, three words back to back
    loop_sel = 1'b1;
    @(negedge clk);
    base  = rxq.size();
    dbase = e2_done_cnt;
    for (int w = 0; w < 3; w++) begin
      t = 0;
      while (!e2_tx_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      check($sformatf("loop ready wait %0d", w), 64'(t < 200), 64'(1));
      e2_tx_valid = 1'b1;
      e2_tx_data  = lb_words[w];
      @(negedge clk);
      e2_tx_valid = 1'b0;
    end
    repeat (60) @(negedge clk);
    check("loop count", 64'(rxq.size() - base), 64'(3));
    for (int w = 0; w < 3; w++) begin
      logic [9:0] got;
      got = 'x;
      if (rxq.size() > base + w) got = rxq[base + w];
      check($sformatf("loop word %0d", w), 64'(got), 64'({lb_words[w], 2'b00}));
    end
    check("loop done count", 64'(e2_done_cnt - dbase), 64'(3));
    loop_sel = 1'b0;

    // Reset mid-frame, then a clean frame
    n1_tx_valid = 1'b1; n1_tx_data = 8'hA5;
    @(negedge clk);
    n1_tx_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset state", 64'(rst_view()), 64'({3'b100, 5'b10000, 8'h00, 3'b000, 8'h00}));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_n1(tx_tab[4].data, tx_tab[4].line, "tx after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
